// File: rtl/tx_lane_scheduler_pkg.sv
// Shared definitions for the TX byte-lane scheduler: state encoding and lane constants.
package tx_lane_scheduler_pkg;

    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned MAX_BURST_DEFAULT = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StServe0 = 2'd1,
        StServe1 = 2'd2
    } state_e;

endpackage

// File: rtl/tx_out_stage.sv
// Registered byte/valid/source slot feeding the serializer; holds its byte while out_ready is low.
module tx_out_stage
    import tx_lane_scheduler_pkg::*;
(
    input  logic              clk,
    input  logic              reset_L,
    input  logic              i_load,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_src,
    input  logic              i_ready,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_src,
    output logic              o_slot_free
);

    logic [BYTE_W-1:0] r_data;
    logic              r_valid;
    logic              r_src;

    // Loads are only issued while the slot is free, so a load never overwrites an unsent byte.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_src   <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
            r_src   <= i_src;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data      = r_data;
    assign o_valid     = r_valid;
    assign o_src       = r_src;
    assign o_slot_free = !r_valid || i_ready;

endmodule

// File: rtl/tx_lane_scheduler.sv
// Work-conserving round-robin arbiter with bounded bursts sharing one TX byte lane
// between two valid/ready requesters; output is registered in tx_out_stage.
module tx_lane_scheduler
    import tx_lane_scheduler_pkg::*;
#(
    parameter int unsigned MAX_BURST = MAX_BURST_DEFAULT,
    parameter int unsigned CNT_W     = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [BYTE_W-1:0] in0_data,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [BYTE_W-1:0] in1_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_src
);

    state_e            r_state, w_state_nxt;
    logic              r_rr_ptr, w_rr_nxt;
    logic [CNT_W-1:0]  r_burst_cnt, w_burst_nxt, w_burst_inc;
    logic              w_slot_free;
    logic              w_xfer0, w_xfer1, w_load;
    logic [BYTE_W-1:0] w_load_data;
    logic              w_own_src, w_own_valid, w_other_valid;
    state_e            w_other_state;

    assign in0_ready   = (r_state == StServe0) && w_slot_free;
    assign in1_ready   = (r_state == StServe1) && w_slot_free;
    assign w_xfer0     = in0_valid && in0_ready;
    assign w_xfer1     = in1_valid && in1_ready;
    assign w_load      = w_xfer0 || w_xfer1;
    assign w_load_data = w_xfer1 ? in1_data : in0_data;

    assign w_own_src     = (r_state == StServe1);
    assign w_own_valid   = w_own_src ? in1_valid : in0_valid;
    assign w_other_valid = w_own_src ? in0_valid : in1_valid;
    assign w_other_state = w_own_src ? StServe0 : StServe1;
    assign w_burst_inc   = r_burst_cnt + CNT_W'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_burst_nxt = r_burst_cnt;
        case (r_state)
            StIdle: begin
                if (in0_valid && in1_valid) begin
                    w_state_nxt = r_rr_ptr ? StServe1 : StServe0;
                end else if (in0_valid) begin
                    w_state_nxt = StServe0;
                end else if (in1_valid) begin
                    w_state_nxt = StServe1;
                end
            end
            StServe0, StServe1: begin
                if (!w_own_valid) begin
                    w_burst_nxt = '0;
                    if (w_other_valid) begin
                        w_state_nxt = w_other_state;
                        w_rr_nxt    = !w_own_src;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else if (w_slot_free) begin
                    // Burst limit only yields when the other side is actually waiting.
                    if (w_burst_inc == CNT_W'(MAX_BURST)) begin
                        w_burst_nxt = '0;
                        if (w_other_valid) begin
                            w_state_nxt = w_other_state;
                            w_rr_nxt    = !w_own_src;
                        end
                    end else begin
                        w_burst_nxt = w_burst_inc;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_burst_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state     <= StIdle;
            r_rr_ptr    <= 1'b0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_burst_cnt <= w_burst_nxt;
        end
    end

    tx_out_stage u_out_stage (
        .clk         (clk),
        .reset_L     (reset_L),
        .i_load      (w_load),
        .i_data      (w_load_data),
        .i_src       (w_xfer1),
        .i_ready     (out_ready),
        .o_data      (out_data),
        .o_valid     (out_valid),
        .o_src       (out_src),
        .o_slot_free (w_slot_free)
    );

endmodule

// File: tb/tb_tx_lane_scheduler.sv
// Directed scoreboard bench: DUT a uses MAX_BURST=4, DUT b uses MAX_BURST=1.
module tb_tx_lane_scheduler;

    logic       clk = 1'b0;
    logic       reset_L;
    always #5 clk = ~clk;

    logic [7:0] a_in0_data, a_in1_data, a_out_data;
    logic       a_in0_valid, a_in1_valid, a_in0_ready, a_in1_ready;
    logic       a_out_ready, a_out_valid, a_out_src;
    logic [7:0] b_in0_data, b_in1_data, b_out_data;
    logic       b_in0_valid, b_in1_valid, b_in0_ready, b_in1_ready;
    logic       b_out_ready, b_out_valid, b_out_src;

    tx_lane_scheduler #(.MAX_BURST(4), .CNT_W(4)) u_dut_a (
        .clk       (clk),
        .reset_L   (reset_L),
        .in0_data  (a_in0_data),
        .in0_valid (a_in0_valid),
        .in0_ready (a_in0_ready),
        .in1_data  (a_in1_data),
        .in1_valid (a_in1_valid),
        .in1_ready (a_in1_ready),
        .out_ready (a_out_ready),
        .out_data  (a_out_data),
        .out_valid (a_out_valid),
        .out_src   (a_out_src)
    );

    tx_lane_scheduler #(.MAX_BURST(1), .CNT_W(4)) u_dut_b (
        .clk       (clk),
        .reset_L   (reset_L),
        .in0_data  (b_in0_data),
        .in0_valid (b_in0_valid),
        .in0_ready (b_in0_ready),
        .in1_data  (b_in1_data),
        .in1_valid (b_in1_valid),
        .in1_ready (b_in1_ready),
        .out_ready (b_out_ready),
        .out_data  (b_out_data),
        .out_valid (b_out_valid),
        .out_src   (b_out_src)
    );

    // Requester byte queues and expected output scoreboards ({src, data}).
    logic [7:0] a_src0_q[$], a_src1_q[$], b_src0_q[$], b_src1_q[$];
    logic [8:0] a_exp_q[$], b_exp_q[$];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int a_last = 0;
    int b_last = 0;
    bit gap_chk = 1'b0;
    bit a_armed = 1'b0;
    bit b_armed = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        a_in0_valid = a_src0_q.size() > 0;
        a_in1_valid = a_src1_q.size() > 0;
        b_in0_valid = b_src0_q.size() > 0;
        b_in1_valid = b_src1_q.size() > 0;
        a_in0_data  = 8'h00;
        a_in1_data  = 8'h00;
        b_in0_data  = 8'h00;
        b_in1_data  = 8'h00;
        if (a_in0_valid) a_in0_data = a_src0_q[0];
        if (a_in1_valid) a_in1_data = a_src1_q[0];
        if (b_in0_valid) b_in0_data = b_src0_q[0];
        if (b_in1_valid) b_in1_data = b_src1_q[0];
    endtask

    task automatic feed(input bit dut_b, input bit k, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (!dut_b && !k) a_src0_q.push_back(base + 8'(i));
            if (!dut_b && k)  a_src1_q.push_back(base + 8'(i));
            if (dut_b && !k)  b_src0_q.push_back(base + 8'(i));
            if (dut_b && k)   b_src1_q.push_back(base + 8'(i));
        end
    endtask

    task automatic expect_bytes(input bit dut_b, input bit k, input logic [7:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (dut_b) b_exp_q.push_back({k, base + 8'(i)});
            else       a_exp_q.push_back({k, base + 8'(i)});
        end
    endtask

    // One clock: handshakes and consumption sampled at negedge, requesters advance after posedge.
    task automatic tick();
        logic       a_acc0, a_acc1, b_acc0, b_acc1;
        logic [8:0] e;
        @(negedge clk);
        a_acc0 = a_in0_valid && a_in0_ready;
        a_acc1 = a_in1_valid && a_in1_ready;
        b_acc0 = b_in0_valid && b_in0_ready;
        b_acc1 = b_in1_valid && b_in1_ready;
        check("a_single_grant", 32'(a_acc0 & a_acc1), 32'd0);
        check("b_single_grant", 32'(b_acc0 & b_acc1), 32'd0);
        if (a_out_valid && a_out_ready) begin
            if (a_exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL a_extra_byte: observed=%0h expected=none", {a_out_src, a_out_data});
            end else begin
                e = a_exp_q.pop_front();
                check("a_data", 32'(a_out_data), 32'(e[7:0]));
                check("a_src", 32'(a_out_src), 32'(e[8]));
                if (gap_chk && a_armed) check("a_gap", 32'(cyc - a_last), 32'd1);
                a_armed = 1'b1;
                a_last  = cyc;
            end
        end
        if (b_out_valid && b_out_ready) begin
            if (b_exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL b_extra_byte: observed=%0h expected=none", {b_out_src, b_out_data});
            end else begin
                e = b_exp_q.pop_front();
                check("b_data", 32'(b_out_data), 32'(e[7:0]));
                check("b_src", 32'(b_out_src), 32'(e[8]));
                if (gap_chk && b_armed) check("b_gap", 32'(cyc - b_last), 32'd1);
                b_armed = 1'b1;
                b_last  = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (a_acc0) void'(a_src0_q.pop_front());
        if (a_acc1) void'(a_src1_q.pop_front());
        if (b_acc0) void'(b_src0_q.pop_front());
        if (b_acc1) void'(b_src1_q.pop_front());
        drive();
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((a_exp_q.size() > 0 || b_exp_q.size() > 0) && n < budget) begin
            tick();
            n++;
        end
        check("drain_pending", 32'(a_exp_q.size() + b_exp_q.size()), 32'd0);
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state, with both requesters asserting valid.
        reset_L     = 1'b0;
        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        drive();
        a_in0_valid = 1'b1;
        a_in1_valid = 1'b1;
        #12;
        check("rst_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_out_data", 32'(a_out_data), 32'h00);
        check("rst_out_src", 32'(a_out_src), 32'd0);
        check("rst_in0_ready", 32'(a_in0_ready), 32'd0);
        check("rst_in1_ready", 32'(a_in1_ready), 32'd0);
        reset_L = 1'b1;
        drive();
        @(posedge clk);
        #1;

        // in0 only, A0..A7 back to back, no switch at burst end.
        gap_chk = 1'b1;
        a_armed = 1'b0;
        feed(0, 0, 8'hA0, 8);
        expect_bytes(0, 0, 8'hA0, 8);
        drive();
        check("idle_bubble_ready", 32'(a_in0_ready), 32'd0);
        tick();
        check("serve0_ready", 32'(a_in0_ready), 32'd1);
        drain(40);

        // Both valid: bursts of 4 alternate with no bubbles.
        a_armed = 1'b0;
        feed(0, 0, 8'h10, 8);
        feed(0, 1, 8'h20, 8);
        expect_bytes(0, 0, 8'h10, 4);
        expect_bytes(0, 1, 8'h20, 4);
        expect_bytes(0, 0, 8'h14, 4);
        expect_bytes(0, 1, 8'h24, 4);
        drive();
        drain(60);

        // rr_ptr is 1 now: in1 served first, drops after 2 bytes, grant moves to in0.
        gap_chk = 1'b0;
        feed(0, 1, 8'h30, 2);
        feed(0, 0, 8'h40, 3);
        expect_bytes(0, 1, 8'h30, 2);
        expect_bytes(0, 0, 8'h40, 3);
        drive();
        repeat (3) tick();
        check("drop_in0_ready_before", 32'(a_in0_ready), 32'd0);
        tick();
        check("drop_in0_ready_after", 32'(a_in0_ready), 32'd1);
        drain(40);

        // rr_ptr went back to 0 on the switch: in0 wins the next contended grant.
        gap_chk = 1'b1;
        a_armed = 1'b0;
        feed(0, 0, 8'h50, 4);
        feed(0, 1, 8'h60, 2);
        expect_bytes(0, 0, 8'h50, 4);
        expect_bytes(0, 1, 8'h60, 2);
        drive();
        drain(40);

        // Backpressure: 55 stalls 3 cycles, nothing accepted, nothing lost.
        gap_chk = 1'b0;
        feed(0, 0, 8'h55, 3);
        expect_bytes(0, 0, 8'h55, 3);
        drive();
        tick();
        tick();
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_valid", 32'(a_out_valid), 32'd1);
            check("stall_data", 32'(a_out_data), 32'h55);
            check("stall_in0_ready", 32'(a_in0_ready), 32'd0);
            check("stall_in1_ready", 32'(a_in1_ready), 32'd0);
        end
        check("stall_no_accept", 32'(a_src0_q.size()), 32'd2);
        a_out_ready = 1'b1;
        drain(40);

        // Reset mid-burst in SERVE1 with 71 held in the output slot.
        feed(0, 1, 8'h70, 10);
        expect_bytes(0, 1, 8'h70, 1);
        drive();
        repeat (3) tick();
        #2;
        reset_L = 1'b0;
        #1;
        check("midrst_out_valid", 32'(a_out_valid), 32'd0);
        check("midrst_out_data", 32'(a_out_data), 32'h00);
        check("midrst_in0_ready", 32'(a_in0_ready), 32'd0);
        check("midrst_in1_ready", 32'(a_in1_ready), 32'd0);
        a_src1_q.delete();
        feed(0, 0, 8'h80, 2);
        feed(0, 1, 8'h90, 2);
        expect_bytes(0, 0, 8'h80, 2);
        expect_bytes(0, 1, 8'h90, 2);
        drive();
        tick();
        tick();
        reset_L = 1'b1;
        drain(40);

        // MAX_BURST=1: strict alternation every cycle.
        gap_chk = 1'b1;
        b_armed = 1'b0;
        feed(1, 0, 8'hB0, 3);
        feed(1, 1, 8'hC0, 3);
        for (int i = 0; i < 3; i++) begin
            expect_bytes(1, 0, 8'hB0 + 8'(i), 1);
            expect_bytes(1, 1, 8'hC0 + 8'(i), 1);
        end
        drive();
        drain(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
